// File: rtl/axi4_st_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// axi4_st_rr_arbiter_pkg
// Shared definitions for the AXI4-Stream round-robin arbiter:
//   state_t       - arbiter FSM encoding (ST_IDLE, ST_GRANT)
//   BEAT_CNT_W    - width of the per-packet beat counter
//   BEAT_CNT_MAX  - saturation value of the beat counter
// -----------------------------------------------------------------------------
package axi4_st_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int                    BEAT_CNT_W   = 16;
    localparam logic [BEAT_CNT_W-1:0] BEAT_CNT_MAX = '1;

endpackage : axi4_st_rr_arbiter_pkg

// File: rtl/axi4_st_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// axi4_st_rr_arbiter_rr_pick
// Combinational round-robin priority picker. Returns the first set bit of req
// searching upward from ptr, wrapping from N_SRC-1 back to 0.
// Ports:
//   req   [N_SRC] - request vector
//   ptr   [ID_W]  - highest-priority index for this search
//   found         - at least one request is set
//   idx   [ID_W]  - winning index (0 when nothing is found)
// -----------------------------------------------------------------------------
module axi4_st_rr_arbiter_rr_pick #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_SRC-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    int              w_base;
    int              w_pos;
    logic [ID_W-1:0] w_cand;

    // NOTE: every variable written here is given a value before any
    //       conditional path, otherwise synthesis infers a latch.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_pos  = 0;
        w_cand = '0;
        // A pointer outside 0..N_SRC-1 cannot occur in normal operation;
        // fall back to 0 so an out-of-range index is never produced.
        w_base = (int'(ptr) < N_SRC) ? int'(ptr) : 0;
        for (int k = 0; k < N_SRC; k++) begin
            // Explicit wrap so non-power-of-2 N_SRC never reaches index N_SRC.
            w_pos = w_base + k;
            if (w_pos >= N_SRC) begin
                w_pos = w_pos - N_SRC;
            end
            w_cand = ID_W'(w_pos);
            if (!found && req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule : axi4_st_rr_arbiter_rr_pick

// File: rtl/axi4_st_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axi4_st_rr_arbiter
// Packet-atomic round-robin arbiter sharing one downstream AXI4-Stream channel
// between N_SRC upstream sources. The grant is registered; the data path is a
// combinational mux steered by it. A grant is held from the first beat until
// the TLAST beat is accepted, then arbitration reruns on the same edge.
// Ports:
//   in_clk, in_rst            - clock, asynchronous active-high reset
//   s_tdata/s_tvalid/s_tlast  - upstream sources (source i at slice i)
//   s_tready                  - per-source ready, only the granted one can be 1
//   m_tdata/m_tvalid/m_tlast  - muxed stream to the sink
//   m_tid                     - index of the granted source
//   m_tready                  - sink ready
//   o_busy                    - a packet grant is held
//   o_pkt_done                - registered pulse after a TLAST beat is accepted
//   o_beat_cnt                - beats accepted in the current packet, saturating
// -----------------------------------------------------------------------------
module axi4_st_rr_arbiter
    import axi4_st_rr_arbiter_pkg::*;
#(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 16,
    parameter int ID_W   = 2
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic [N_SRC*DATA_W-1:0] s_tdata,
    input  logic [N_SRC-1:0]        s_tvalid,
    input  logic [N_SRC-1:0]        s_tlast,
    output logic [N_SRC-1:0]        s_tready,
    output logic [DATA_W-1:0]       m_tdata,
    output logic                    m_tvalid,
    output logic                    m_tlast,
    output logic [ID_W-1:0]         m_tid,
    input  logic                    m_tready,
    output logic                    o_busy,
    output logic                    o_pkt_done,
    output logic [BEAT_CNT_W-1:0]   o_beat_cnt
);

    state_t                r_state,    w_state_nxt;
    logic [ID_W-1:0]       r_gnt_idx,  w_gnt_nxt;
    logic [ID_W-1:0]       r_rr_ptr,   w_ptr_nxt;
    logic [BEAT_CNT_W-1:0] r_beat_cnt, w_cnt_nxt;
    logic                  r_pkt_done, w_done_nxt;

    logic [ID_W-1:0]       w_gnt_inc;
    logic                  w_idle_found, w_b2b_found;
    logic [ID_W-1:0]       w_idle_idx,   w_b2b_idx;
    logic                  w_beat, w_last_beat;
    logic [DATA_W-1:0]     w_src_data [N_SRC];

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_unpack
        assign w_src_data[gi] = s_tdata[gi*DATA_W +: DATA_W];
    end

    // Source after the current grant, wrapping explicitly at N_SRC-1.
    assign w_gnt_inc = (r_gnt_idx == ID_W'(N_SRC - 1)) ? '0 : r_gnt_idx + ID_W'(1);

    // Arbitration out of IDLE starts at the stored pointer.
    axi4_st_rr_arbiter_rr_pick #(.N_SRC(N_SRC), .ID_W(ID_W)) u_pick_idle (
        .req   (s_tvalid),
        .ptr   (r_rr_ptr),
        .found (w_idle_found),
        .idx   (w_idle_idx)
    );

    // Back-to-back arbitration on the last beat starts just past the source
    // that is finishing, so it only wins again when nobody else requests.
    axi4_st_rr_arbiter_rr_pick #(.N_SRC(N_SRC), .ID_W(ID_W)) u_pick_b2b (
        .req   (s_tvalid),
        .ptr   (w_gnt_inc),
        .found (w_b2b_found),
        .idx   (w_b2b_idx)
    );

    // Data path: everything is zero unless a grant is held.
    always_comb begin
        s_tready = '0;
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tlast  = 1'b0;
        m_tid    = '0;
        o_busy   = 1'b0;
        if (r_state == ST_GRANT) begin
            m_tvalid            = s_tvalid[r_gnt_idx];
            m_tdata             = w_src_data[r_gnt_idx];
            m_tlast             = s_tlast[r_gnt_idx];
            m_tid               = r_gnt_idx;
            s_tready[r_gnt_idx] = m_tready;
            o_busy              = 1'b1;
        end
    end

    assign w_beat      = m_tvalid & m_tready;
    assign w_last_beat = w_beat & m_tlast;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt_idx;
        w_ptr_nxt   = r_rr_ptr;
        w_cnt_nxt   = r_beat_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_idle_found) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = w_idle_idx;
                end
            end
            ST_GRANT: begin
                // The grant is released only by an accepted TLAST beat; a
                // source dropping tvalid mid-packet keeps the channel locked.
                if (w_last_beat) begin
                    w_ptr_nxt  = w_gnt_inc;
                    w_cnt_nxt  = '0;
                    w_done_nxt = 1'b1;
                    if (w_b2b_found) begin
                        w_gnt_nxt = w_b2b_idx;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_beat && (r_beat_cnt != BEAT_CNT_MAX)) begin
                    w_cnt_nxt = r_beat_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    //       samples the pre-edge values, independent of statement order.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_state    <= ST_IDLE;
            r_gnt_idx  <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_pkt_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt_idx  <= w_gnt_nxt;
            r_rr_ptr   <= w_ptr_nxt;
            r_beat_cnt <= w_cnt_nxt;
            r_pkt_done <= w_done_nxt;
        end
    end

    assign o_pkt_done = r_pkt_done;
    assign o_beat_cnt = r_beat_cnt;

endmodule : axi4_st_rr_arbiter

// File: tb/tb_axi4_st_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi4_st_rr_arbiter
// Self-checking bench for axi4_st_rr_arbiter (N_SRC=4, DATA_W=16). Inputs are
// driven 1 time unit after the rising edge, outputs sampled on the falling
// edge. Accepted beats are compared against a queue of expected beats.
// -----------------------------------------------------------------------------
module tb_axi4_st_rr_arbiter;

    localparam int N_SRC  = 4;
    localparam int DATA_W = 16;
    localparam int ID_W   = 2;

    logic                    in_clk;
    logic                    in_rst;
    logic [N_SRC*DATA_W-1:0] s_tdata;
    logic [N_SRC-1:0]        s_tvalid;
    logic [N_SRC-1:0]        s_tlast;
    logic [N_SRC-1:0]        s_tready;
    logic [DATA_W-1:0]       m_tdata;
    logic                    m_tvalid;
    logic                    m_tlast;
    logic [ID_W-1:0]         m_tid;
    logic                    m_tready;
    logic                    o_busy;
    logic                    o_pkt_done;
    logic [15:0]             o_beat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [ID_W-1:0]   tid;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t sb[$];

    typedef struct packed {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        ready;
        logic        exp_valid;
        logic [1:0]  exp_tid;
        logic [15:0] exp_data;
        logic [3:0]  exp_sready;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    vec_t tbl [6];

    axi4_st_rr_arbiter #(
        .N_SRC  (N_SRC),
        .DATA_W (DATA_W),
        .ID_W   (ID_W)
    ) dut (
        .in_clk     (in_clk),
        .in_rst     (in_rst),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .m_tid      (m_tid),
        .m_tready   (m_tready),
        .o_busy     (o_busy),
        .o_pkt_done (o_pkt_done),
        .o_beat_cnt (o_beat_cnt)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no end of test, required end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] tid,
                           input logic [15:0] d, input logic [3:0] sr,
                           input logic busy, input logic done, input logic [15:0] cnt);
        check({tag, ".m_tvalid"},   m_tvalid,   v);
        check({tag, ".m_tid"},      m_tid,      tid);
        check({tag, ".m_tdata"},    m_tdata,    d);
        check({tag, ".s_tready"},   s_tready,   sr);
        check({tag, ".o_busy"},     o_busy,     busy);
        check({tag, ".o_pkt_done"}, o_pkt_done, done);
        check({tag, ".o_beat_cnt"}, o_beat_cnt, cnt);
    endtask

    task automatic cyc();
        @(posedge in_clk);
        #1;
    endtask

    task automatic set_d(input int i, input logic [15:0] v);
        s_tdata[i*DATA_W +: DATA_W] = v;
    endtask

    task automatic push(input logic [1:0] tid, input logic [15:0] d, input logic last);
        beat_t b;
        b.tid  = tid;
        b.data = d;
        b.last = last;
        sb.push_back(b);
    endtask

    // Asserts reset at once, checks reset outputs, releases two cycles later.
    task automatic do_reset(input logic [3:0] v);
        check("sb_drained_before_reset", sb.size(), 0);
        in_rst   = 1'b1;
        s_tvalid = v;
        s_tlast  = '0;
        m_tready = 1'b1;
        @(negedge in_clk);
        chk_out("rst", 1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0, 1'b0, 16'd0);
        check("rst.m_tlast", m_tlast, 1'b0);
        cyc();
        cyc();
        sb.delete();
        in_rst = 1'b0;
    endtask

    // Scoreboard monitor: a beat is accepted at the next rising edge.
    always @(negedge in_clk) begin
        if (!in_rst && m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_beat: got tid %0d data %0h, required no beat", m_tid, m_tdata);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("sb.tid",   m_tid,   e.tid);
                check("sb.tdata", m_tdata, e.data);
                check("sb.tlast", m_tlast, e.last);
            end
        end
    end

    initial begin
        in_rst   = 1'b1;
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b0;

        // Round-robin over single-beat packets, no bubbles after the first.
        tbl[0] = '{4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0, 1'b0};
        tbl[1] = '{4'hF, 4'hF, 1'b1, 1'b1, 2'd0, 16'hA000, 4'b0001, 1'b1, 1'b0};
        tbl[2] = '{4'hF, 4'hF, 1'b1, 1'b1, 2'd1, 16'hA001, 4'b0010, 1'b1, 1'b1};
        tbl[3] = '{4'hF, 4'hF, 1'b1, 1'b1, 2'd2, 16'hA002, 4'b0100, 1'b1, 1'b1};
        tbl[4] = '{4'hF, 4'hF, 1'b1, 1'b1, 2'd3, 16'hA003, 4'b1000, 1'b1, 1'b1};
        tbl[5] = '{4'hF, 4'hF, 1'b1, 1'b1, 2'd0, 16'hA000, 4'b0001, 1'b1, 1'b1};

        cyc();
        do_reset(4'b0000);
        for (int i = 0; i < N_SRC; i++) set_d(i, 16'hA000 + 16'(i));
        for (int r = 0; r < 6; r++) begin
            s_tvalid = tbl[r].valid;
            s_tlast  = tbl[r].last;
            m_tready = tbl[r].ready;
            if (tbl[r].exp_valid && tbl[r].ready) push(tbl[r].exp_tid, tbl[r].exp_data, 1'b1);
            @(negedge in_clk);
            chk_out($sformatf("rr[%0d]", r), tbl[r].exp_valid, tbl[r].exp_tid, tbl[r].exp_data,
                    tbl[r].exp_sready, tbl[r].exp_busy, tbl[r].exp_done, 16'd0);
            cyc();
        end

        // Reset mid-stream with all sources valid; first grant one cycle after release.
        do_reset(4'b1111);
        s_tlast  = 4'hF;
        m_tready = 1'b1;
        @(negedge in_clk);
        chk_out("t1_c0", 1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0, 1'b0, 16'd0);
        cyc();
        push(2'd0, 16'hA000, 1'b1);
        @(negedge in_clk);
        chk_out("t1_c1", 1'b1, 2'd0, 16'hA000, 4'b0001, 1'b1, 1'b0, 16'd0);
        cyc();

        // Packet lock on source 1 with source 2 waiting, then backpressure.
        do_reset(4'b0000);
        set_d(1, 16'hB101);
        set_d(2, 16'hC200);
        s_tvalid = 4'b0110;
        s_tlast  = 4'b0000;
        m_tready = 1'b1;
        @(negedge in_clk);
        chk_out("t3_c0", 1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0, 1'b0, 16'd0);
        cyc();
        push(2'd1, 16'hB101, 1'b0);
        @(negedge in_clk);
        chk_out("t3_c1", 1'b1, 2'd1, 16'hB101, 4'b0010, 1'b1, 1'b0, 16'd0);
        cyc();
        set_d(1, 16'hB102);
        push(2'd1, 16'hB102, 1'b0);
        @(negedge in_clk);
        chk_out("t3_c2", 1'b1, 2'd1, 16'hB102, 4'b0010, 1'b1, 1'b0, 16'd1);
        cyc();
        set_d(1, 16'hB103);
        s_tlast = 4'b0010;
        push(2'd1, 16'hB103, 1'b1);
        @(negedge in_clk);
        chk_out("t3_c3", 1'b1, 2'd1, 16'hB103, 4'b0010, 1'b1, 1'b0, 16'd2);
        cyc();
        s_tvalid = 4'b0100;
        s_tlast  = 4'b0000;
        push(2'd2, 16'hC200, 1'b0);
        @(negedge in_clk);
        chk_out("t3_c4", 1'b1, 2'd2, 16'hC200, 4'b0100, 1'b1, 1'b1, 16'd0);
        cyc();
        s_tvalid = 4'b0110;
        s_tlast  = 4'b0110;
        set_d(1, 16'hB104);
        set_d(2, 16'hC201);
        m_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge in_clk);
            chk_out($sformatf("t4_hold[%0d]", k), 1'b1, 2'd2, 16'hC201, 4'b0000, 1'b1, 1'b0, 16'd1);
            cyc();
        end
        m_tready = 1'b1;
        push(2'd2, 16'hC201, 1'b1);
        @(negedge in_clk);
        chk_out("t4_release", 1'b1, 2'd2, 16'hC201, 4'b0100, 1'b1, 1'b0, 16'd1);
        cyc();
        m_tready = 1'b0;
        @(negedge in_clk);
        chk_out("t3_wrap", 1'b1, 2'd1, 16'hB104, 4'b0000, 1'b1, 1'b1, 16'd0);
        check("t3_wrap.m_tlast", m_tlast, 1'b1);
        cyc();

        // Lone requester: source 3 regranted back-to-back without an idle cycle.
        do_reset(4'b0000);
        set_d(3, 16'hD300);
        s_tvalid = 4'b1000;
        s_tlast  = 4'b1000;
        m_tready = 1'b1;
        @(negedge in_clk);
        chk_out("t5_c0", 1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0, 1'b0, 16'd0);
        cyc();
        push(2'd3, 16'hD300, 1'b1);
        @(negedge in_clk);
        chk_out("t5_c1", 1'b1, 2'd3, 16'hD300, 4'b1000, 1'b1, 1'b0, 16'd0);
        cyc();
        set_d(3, 16'hD301);
        push(2'd3, 16'hD301, 1'b1);
        @(negedge in_clk);
        chk_out("t5_c2", 1'b1, 2'd3, 16'hD301, 4'b1000, 1'b1, 1'b1, 16'd0);
        cyc();
        s_tvalid = 4'b0000;
        m_tready = 1'b0;
        @(negedge in_clk);
        chk_out("t5_c3", 1'b0, 2'd3, 16'hD301, 4'b0000, 1'b1, 1'b1, 16'd0);
        cyc();

        // Granted source 0 drops tvalid mid-packet; source 1 must stay stalled.
        do_reset(4'b0000);
        set_d(0, 16'hE000);
        set_d(1, 16'hE100);
        s_tvalid = 4'b0011;
        s_tlast  = 4'b0000;
        m_tready = 1'b1;
        @(negedge in_clk);
        chk_out("t6_c0", 1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0, 1'b0, 16'd0);
        cyc();
        push(2'd0, 16'hE000, 1'b0);
        @(negedge in_clk);
        chk_out("t6_c1", 1'b1, 2'd0, 16'hE000, 4'b0001, 1'b1, 1'b0, 16'd0);
        cyc();
        s_tvalid = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            @(negedge in_clk);
            chk_out($sformatf("t6_drop[%0d]", k), 1'b0, 2'd0, 16'hE000, 4'b0001, 1'b1, 1'b0, 16'd1);
            cyc();
        end
        s_tvalid = 4'b0011;
        s_tlast  = 4'b0001;
        set_d(0, 16'hE001);
        push(2'd0, 16'hE001, 1'b1);
        @(negedge in_clk);
        chk_out("t6_c4", 1'b1, 2'd0, 16'hE001, 4'b0001, 1'b1, 1'b0, 16'd1);
        cyc();
        m_tready = 1'b0;
        @(negedge in_clk);
        chk_out("t6_c5", 1'b1, 2'd1, 16'hE100, 4'b0000, 1'b1, 1'b1, 16'd0);
        cyc();

        check("sb_drained_at_end", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_axi4_st_rr_arbiter

// File: doc/axi4_st_rr_arbiter.md
Name: axi4_st_rr_arbiter

Overview:
Round-robin arbiter that shares one downstream AXI4-Stream channel, such as the output buffer path, between N upstream stream sources. Arbitration is packet-atomic. A grant is held from the first beat until the TLAST beat is accepted. The data path is a combinational mux steered by a registered grant. The FSM, grant pointer and beat counter are all registered.

Parameters:
N_SRC, 4, number of upstream stream sources (2..8)
DATA_W, 16, TDATA width in bits
ID_W, 2, width of grant index, must equal clog2(N_SRC)

Ports:
in_clk  input  1  clock, all state on rising edge
in_rst  input  1  asynchronous active-high reset
s_tdata  input  N_SRC*DATA_W  source data, source i at bits [i*DATA_W +: DATA_W]
s_tvalid  input  N_SRC  source valid
s_tlast  input  N_SRC  source end-of-packet
s_tready  output  N_SRC  per-source ready
m_tdata  output  DATA_W  muxed data to sink
m_tvalid  output  1  muxed valid
m_tlast  output  1  muxed last
m_tid  output  ID_W  index of granted source, sideband
m_tready  input  1  sink ready (buffer empty/accepting)
o_busy  output  1  high while a packet grant is held
o_pkt_done  output  1  one-cycle pulse, registered, after TLAST beat accepted
o_beat_cnt  output  16  beats accepted in current packet, saturating

Behaviour:
- States: IDLE, GRANT. Registers: state, gnt_idx[ID_W], rr_ptr[ID_W], beat_cnt, pkt_done.
- Reset (async, in_rst=1): state=IDLE, gnt_idx=0, rr_ptr=0, beat_cnt=0, pkt_done=0.
- Outputs during reset: s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, m_tid=0, o_busy=0.
- IDLE: outputs forced low (m_tdata=0, s_tready=0).
- IDLE arbitration: if any s_tvalid, the winner is the first set bit searching from rr_ptr upward with wrap at N_SRC-1 to 0. On that edge, gnt_idx is set to the winner and state becomes GRANT.
- Arbitration latency: one cycle from the first valid in IDLE to m_tvalid.
- GRANT: m_tvalid=s_tvalid[g], m_tdata=s_tdata[g], m_tlast=s_tlast[g], m_tid=g, s_tready[g]=m_tready. All other s_tready bits are 0. o_busy=1.
- Beat: a beat is m_tvalid&&m_tready. Each beat increments beat_cnt, saturating at 16'hFFFF.
- Last beat (beat with m_tlast): rr_ptr=g+1 mod N_SRC. pkt_done pulses on the next cycle. beat_cnt clears to 0.
- Back-to-back: on the last-beat edge, arbitration reruns over the current s_tvalid with the pointer g+1.
  - If a winner exists, state stays GRANT and gnt_idx becomes the winner, with no idle cycle.
  - If there is no winner, state goes to IDLE.
  - The source that just finished is lowest priority but may win if it is the only requester.
- Grant lock: the granted source dropping s_tvalid mid-packet does not release the grant. Other sources stay stalled until its TLAST beat.
- m_tready low: hold, no state change. The data path is combinational, so the source must hold data per AXI rules.
- Single-beat packets (tlast on the first beat) with all sources valid: sustained throughput of 1 beat/cycle after the initial latency, grants cycling 0,1,2,3,0...
- N_SRC not a power of 2: the pointer wraps explicitly, and indices >= N_SRC are never granted.
- Reset mid-packet: immediate return to the reset state. The partial packet is abandoned; the sink framing is the sink's concern.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_GRANT) and the BEAT_CNT_W=16 constant.
- Sub-module rr_pick: a combinational round-robin priority picker.
  - Inputs: req[N_SRC], ptr[ID_W].
  - Outputs: found, idx[ID_W].
  - Used at both arbitration points.

Test Plan:
1. Reset and idle: assert in_rst mid-sim with s_tvalid=4'b1111 -> s_tready=0, m_tvalid=0, o_busy=0, m_tid=0. Release -> first grant to source 0 one cycle later.
2. Round-robin: all 4 sources send 1-beat packets, data 16'hA000+i, m_tready=1 -> m_tid sequence 0,1,2,3,0, m_tdata A000,A001,A002,A003,A000, no bubble after the first beat.
3. Packet lock: source 1 sends 3 beats (tlast on beat 3) while source 2 is valid -> s_tready[2]=0 until source 1's last beat. o_beat_cnt 1,2,then 0. o_pkt_done pulses once. Next m_tid=2.
4. Backpressure: m_tready=0 for 5 cycles mid-packet -> m_tdata stable, beat_cnt frozen, grant unchanged.
5. Lone requester: only source 3 valid, two packets back-to-back -> source 3 regranted immediately (GRANT->GRANT), m_tid=3 both times.
6. Valid drop: granted source 0 drops s_tvalid for 2 cycles mid-packet while source 1 is valid -> m_tvalid=0, o_busy=1, no switch to source 1.
